// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, data word and the
// memory-arbiter state encoding used by the caches wrapper.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Arbiter FSM encoding, named so caches-level waveforms decode it.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IGNT = 2'd1,
      ARB_DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between the icache and dcache.
// dcache has fixed priority; a streak counter forces an icache grant
// after STARVE_LIMIT dcache completions while the icache is waiting.
// A grant is registered and held until the RAM reports ACCESS.
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   localparam logic [1:0] IDLE = ARB_IDLE;
   localparam logic [1:0] IGNT = ARB_IGNT;
   localparam logic [1:0] DGNT = ARB_DGNT;

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [CNT_W-1:0] streak_r;
   logic [CNT_W-1:0] streak_nxt_s;
   logic             dreq_s;
   logic             access_s;

   // Priority pick; the streak used already includes this cycle's completion
   // so the icache wins right after the LIMIT-th dcache completion.
   function automatic logic [1:0] arbitrate(input logic ireq, input logic dreq,
                                            input logic [CNT_W-1:0] streak);
      logic [1:0] pick;
      if (ireq && (streak == LIMIT_C)) begin
         pick = IGNT;
      end else if (dreq) begin
         pick = DGNT;
      end else if (ireq) begin
         pick = IGNT;
      end else begin
         pick = IDLE;
      end
      return pick;
   endfunction

   assign dreq_s   = dREN | dWEN;
   assign access_s = (ramstate == ACCESS);

   // Streak of dcache completions while the icache is kept waiting.
   always_comb begin
      streak_nxt_s = streak_r;
      if (!iREN) begin
         streak_nxt_s = ZERO_C;
      end else if ((state_r == IGNT) && access_s) begin
         streak_nxt_s = ZERO_C;
      end else if ((state_r == DGNT) && access_s && (streak_r != LIMIT_C)) begin
         streak_nxt_s = streak_r + ONE_C;
      end else begin
         streak_nxt_s = streak_r;
      end
   end

   // Next grant: re-arbitrate from IDLE, on completion, or when the owner lets go.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            state_nxt_s = arbitrate(iREN, dreq_s, streak_nxt_s);
         end
         IGNT: begin
            if (access_s || !iREN) begin
               state_nxt_s = arbitrate(iREN, dreq_s, streak_nxt_s);
            end else begin
               state_nxt_s = IGNT;
            end
         end
         DGNT: begin
            if (access_s || !dreq_s) begin
               state_nxt_s = arbitrate(iREN, dreq_s, streak_nxt_s);
            end else begin
               state_nxt_s = DGNT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and streak registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= IDLE;
         streak_r <= ZERO_C;
      end else begin
         state_r  <= state_nxt_s;
         streak_r <= streak_nxt_s;
      end
   end

   // RAM drive and requester handshakes; enables follow the owner's request live.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'h0000_0000;
      ramstore = 32'h0000_0000;
      iwait    = 1'b1;
      iload    = 32'h0000_0000;
      dwait    = 1'b1;
      dload    = 32'h0000_0000;
      if (RST) begin
         ramREN = 1'b0;
         ramWEN = 1'b0;
      end else begin
         case (state_r)
            IGNT: begin
               ramREN  = iREN;
               ramaddr = iaddr;
               if (access_s) begin
                  iwait = 1'b0;
                  iload = ramload;
               end else begin
                  iwait = 1'b1;
                  iload = 32'h0000_0000;
               end
            end
            DGNT: begin
               ramaddr  = daddr;
               ramstore = dstore;
               if (dWEN) begin
                  ramWEN = 1'b1;
                  ramREN = 1'b0;
               end else begin
                  ramWEN = 1'b0;
                  ramREN = dREN;
               end
               if (access_s) begin
                  dwait = 1'b0;
                  dload = ramload;
               end else begin
                  dwait = 1'b1;
                  dload = 32'h0000_0000;
               end
            end
            default: begin
               ramREN = 1'b0;
               ramWEN = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences the single shared RAM port between the icache and dcache miss/writeback paths that sit inside the caches wrapper.
- Fixed dcache priority, with an icache anti-starvation streak counter.
- Grants are registered, and each grant is held until RAM completion.
- Sits between the caches_if requester side and the RAM controller's request/ramstate interface.

Parameters:
- STARVE_LIMIT, 4: consecutive dcache completions allowed while icache waits before icache is forced to win.
- CNT_W, 3: width of the streak counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  in  1  clock; all state updates on posedge CLK.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low only in the cycle icache data is valid.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low only in the cycle the dcache transaction completes.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- FSM states: IDLE, IGNT, DGNT. Reset values: state=IDLE, streak=0.
- While RST is high, outputs are forced regardless of state: ramREN=0, ramWEN=0, iwait=1, dwait=1.
- Arbitration rule, evaluated in IDLE, or in a grant state on its ACCESS cycle:
  - If iREN and streak==STARVE_LIMIT: next=IGNT.
  - Else if dREN|dWEN: next=DGNT.
  - Else if iREN: next=IGNT.
  - Else: next=IDLE.
- Latency: a request first seen in IDLE is driven to RAM in the following cycle. Minimum is 1 arbitration cycle plus RAM latency.
- Back-to-back grants: on ACCESS, the next grant is taken directly with no idle bubble.
- IGNT outputs: ramREN=1, ramWEN=0, ramaddr=iaddr. iwait=0 and iload=ramload only when ramstate==ACCESS.
- DGNT outputs: ramaddr=daddr and ramstore=dstore. If dWEN, then ramWEN=1 and ramREN=0; write wins when dREN and dWEN are both high. Otherwise ramREN=dREN. dwait=0 and dload=ramload only on ACCESS.
- Requests from the non-granted side see wait=1 and load=0. Idle RAM outputs are 0.
- BUSY/FREE while granted: stay in the grant state and hold outputs stable.
- ERROR: treat as BUSY, stay granted with wait=1. RAM retry is the RAM's responsibility.
- Requester deasserts before ACCESS: RAM enables drop the same cycle (combinational) and the state returns to arbitration. The next state follows the arbitration rule; no completion is signalled.
- Streak counter:
  - Increments on a DGNT ACCESS while iREN=1.
  - Clears on an IGNT ACCESS, or in any cycle with iREN=0.
  - Saturates at STARVE_LIMIT.
- Simultaneous iREN and dREN in IDLE with streak<STARVE_LIMIT: dcache wins.
- Reset mid-transaction: state returns to IDLE and streak=0 at the next edge. The RAM request drops immediately.

Decomposition:
- ramstate_t and word_t live in cpu_types_pkg and are reused.
- arb_state_t (IDLE/IGNT/DGNT) is added to cpu_types_pkg for waveform visibility in caches-level benches.
- No sub-module: single FSM plus counter. Instantiated by caches alongside icache and dcache, wired through caches_if.

Test Plan:
- Reset: RST=1 for 2 cycles with all requests high -> ramREN=0, ramWEN=0, iwait=1, dwait=1. The first grant appears in the cycle after RST falls.
- Lone icache read: iREN=1, iaddr=0x100, RAM ACCESS 2 cycles after grant with ramload=0xDEADBEEF -> ramaddr=0x100, and iwait=0 with iload=0xDEADBEEF exactly on the ACCESS cycle.
- Contention: iREN and dREN rise together, daddr=0x200 -> DGNT first. After dcache ACCESS, IGNT the next cycle with no bubble.
- Starvation: iREN held while dREN issues 6 back-to-back accesses, STARVE_LIMIT=4 -> icache granted after the 4th dcache completion. The streak returns to 0 after the icache completes.
- Write precedence and ERROR: dREN=dWEN=1, dstore=0x12345678, RAM returns ERROR for 2 cycles then ACCESS -> ramWEN=1, ramREN=0 throughout, and dwait=0 only on ACCESS.
- Abort: dREN dropped mid-BUSY with iREN=1 -> ramREN falls the same cycle and IGNT follows at the next edge. dwait never goes low.
